controle_display_erros: RTL and testbench

Error-display scheduler for the coffee machine's multiplexed 4-digit seven-segment panel. Up to four error sources (sensor SR, water level, temperature, cup) raise sticky requests. The block shares the single panel between them round-robin, holding each active error for a fixed number of scan frames. For the error being shown, it generates the 2-bit letter-select (`sel_contador`) consumed by the per-error letter decoders and the active-low digit enables.

---
 rtl/controle_display_erros.sv | 136 +++++++++++++
 tb/tb_controle_display_erros.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/controle_display_erros.sv
// Round-robin error-display scheduler for the 4-digit multiplexed panel.
// Optional blank frame between holds is compiled in with ERRO_GAP_EN.
module controle_display_erros #(
  parameter int SCAN_DIV   = 50000,
  parameter int HOLD_SCANS = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] erro_req,
  output logic [1:0] sel_contador,
  output logic [3:0] digito_n,
  output logic [1:0] erro_atual,
  output logic       erro_valido,
  output logic [3:0] erro_visto
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (HOLD_SCANS > 1) ? $clog2(HOLD_SCANS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_NEXT = 2'd2
`ifdef ERRO_GAP_EN
    , ST_GAP = 2'd3
`endif
  } state_t;

  state_t          r_state;
  logic [1:0]      r_ptr;
  logic [DW-1:0]   r_div;
  logic [1:0]      r_dig;
  logic [FW-1:0]   r_frame;
  logic [3:0]      r_pend;

  logic            w_any;
  logic            w_found;
  logic [1:0]      w_sel;
  logic [1:0]      w_idx;
  logic            w_tick;
  logic            w_wrap;
  logic            w_last;

  // First active request scanning circularly from the round-robin pointer.
  always_comb begin
    w_any   = |erro_req;
    w_sel   = r_ptr;
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && erro_req[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_tick = (r_div == DW'(SCAN_DIV - 1));
  assign w_wrap = w_tick && (r_dig == 2'd3);
  assign w_last = w_wrap && (r_frame == FW'(HOLD_SCANS - 1));

  // Panel outputs are registered from the current state, so they trail the
  // state register by one cycle; the completion pulse is delayed to match.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= 2'd0;
      r_div        <= '0;
      r_dig        <= 2'd0;
      r_frame      <= '0;
      r_pend       <= 4'b0000;
      sel_contador <= 2'd0;
      digito_n     <= 4'b1111;
      erro_atual   <= 2'd0;
      erro_valido  <= 1'b0;
      erro_visto   <= 4'b0000;
    end else begin
      r_pend     <= 4'b0000;
      erro_visto <= r_pend;
      if (r_state == ST_SHOW) begin
        sel_contador <= r_dig;
        digito_n     <= ~(4'b0001 << r_dig);
        erro_valido  <= 1'b1;
      end else begin
        sel_contador <= 2'd0;
        digito_n     <= 4'b1111;
        erro_valido  <= 1'b0;
      end

      case (r_state)
        ST_IDLE, ST_NEXT: begin
          r_div   <= '0;
          r_dig   <= 2'd0;
          r_frame <= '0;
          if (w_any) begin
            erro_atual <= w_sel;
            r_ptr      <= w_sel + 2'd1;
            r_state    <= ST_SHOW;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHOW: begin
          if (!erro_req[erro_atual]) begin
            r_state <= ST_NEXT;
            r_div   <= '0;
            r_dig   <= 2'd0;
            r_frame <= '0;
          end else begin
            r_div <= w_tick ? '0 : r_div + DW'(1);
            if (w_tick) r_dig <= r_dig + 2'd1;
            if (w_wrap) r_frame <= (r_frame == FW'(HOLD_SCANS - 1)) ? '0 : r_frame + FW'(1);
            if (w_last) begin
              r_pend <= 4'b0001 << erro_atual;
`ifdef ERRO_GAP_EN
              r_state <= ST_GAP;
`else
              r_state <= ST_NEXT;
`endif
            end
          end
        end
`ifdef ERRO_GAP_EN
        ST_GAP: begin
          r_div <= w_tick ? '0 : r_div + DW'(1);
          if (w_tick) r_dig <= r_dig + 2'd1;
          if (w_wrap) r_state <= ST_NEXT;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_display_erros.sv
// Table-driven bench for controle_display_erros (SCAN_DIV=2, HOLD_SCANS=2);
// expectations follow the ERRO_GAP_EN setting of the build.
module tb_controle_display_erros;

  localparam int SCAN_DIV   = 2;
  localparam int HOLD_SCANS = 2;
  localparam int HOLD_CYC   = 4 * SCAN_DIV * HOLD_SCANS;
`ifdef ERRO_GAP_EN
  localparam int GAPC = 4 * SCAN_DIV;
`else
  localparam int GAPC = 0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] erro_req = 4'b0000;
  logic [1:0] sel_contador;
  logic [3:0] digito_n;
  logic [1:0] erro_atual;
  logic       erro_valido;
  logic [3:0] erro_visto;

  int n_checks = 0;
  int n_fail   = 0;

  controle_display_erros #(.SCAN_DIV(SCAN_DIV), .HOLD_SCANS(HOLD_SCANS)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .erro_req    (erro_req),
    .sel_contador(sel_contador),
    .digito_n    (digito_n),
    .erro_atual  (erro_atual),
    .erro_valido (erro_valido),
    .erro_visto  (erro_visto)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // {sel, digito_n, atual, valido, visto}
  typedef struct packed {
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] dn;
    logic [1:0] atual;
    logic       val;
    logic [3:0] visto;
  } vec_t;

  vec_t vq[$];

  function automatic logic [12:0] outs();
    return {sel_contador, digito_n, erro_atual, erro_valido, erro_visto};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got sel=%0d dn=%b atual=%0d val=%b visto=%b, expected sel=%0d dn=%b atual=%0d val=%b visto=%b",
               name, act[12:11], act[10:7], act[6:5], act[4], act[3:0],
               exp[12:11], exp[10:7], exp[6:5], exp[4], exp[3:0]);
    end
  endtask

  localparam logic [12:0] RESET_OUTS = {2'd0, 4'b1111, 2'd0, 1'b0, 4'b0000};

  task automatic do_reset();
    reset_n  = 1'b0;
    erro_req = 4'b0000;
    @(posedge clock); #1;
    check("reset_state", outs(), RESET_OUTS);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- table builders ----------------
  function automatic void add_v(input logic [3:0] req, input logic [1:0] sel, input logic [3:0] dn,
                                input logic [1:0] atual, input logic val, input logic [3:0] visto);
    vec_t v;
    v.req = req; v.sel = sel; v.dn = dn; v.atual = atual; v.val = val; v.visto = visto;
    vq.push_back(v);
  endfunction

  function automatic void add_lit(input logic [3:0] req, input int d, input logic [1:0] atual);
    logic [3:0] one;
    one = 4'b0001 << d;
    add_v(req, 2'(d), ~one, atual, 1'b1, 4'b0000);
  endfunction

  // One full hold of 'cur', then the blank cycles, ending with 'nxt' loaded.
  function automatic void add_hold(input logic [3:0] req, input logic [1:0] cur, input logic [1:0] nxt);
    logic [3:0] oh;
    oh = 4'b0001 << cur;
    for (int k = 0; k < HOLD_CYC; k++) add_lit(req, (k / SCAN_DIV) % 4, cur);
    for (int j = 0; j <= GAPC; j++)
      add_v(req, 2'd0, 4'b1111, (j == GAPC) ? nxt : cur, 1'b0, (j == 0) ? oh : 4'b0000);
  endfunction

  // ---------------- driver ----------------
  task automatic run_table(input string tname);
    for (int i = 0; i < vq.size(); i++) begin
      erro_req = vq[i].req;
      @(posedge clock); #1;
      check($sformatf("%s[%0d]", tname, i), outs(),
            {vq[i].sel, vq[i].dn, vq[i].atual, vq[i].val, vq[i].visto});
    end
    vq.delete();
  endtask

  // ---------------- test ----------------
  initial begin
    // Single persistent request: hold repeats for the same error.
    do_reset();
    add_v(4'b0000, 2'd0, 4'b1111, 2'd0, 1'b0, 4'b0000);
    add_v(4'b0000, 2'd0, 4'b1111, 2'd0, 1'b0, 4'b0000);
    add_v(4'b0001, 2'd0, 4'b1111, 2'd0, 1'b0, 4'b0000);
    add_hold(4'b0001, 2'd0, 2'd0);
    add_hold(4'b0001, 2'd0, 2'd0);
    add_lit(4'b0001, 0, 2'd0);
    add_lit(4'b0001, 0, 2'd0);
    run_table("single");

    // Round robin between errors 1 and 3.
    do_reset();
    add_v(4'b1010, 2'd0, 4'b1111, 2'd1, 1'b0, 4'b0000);
    add_hold(4'b1010, 2'd1, 2'd3);
    add_hold(4'b1010, 2'd3, 2'd1);
    add_hold(4'b1010, 2'd1, 2'd3);
    add_lit(4'b1010, 0, 2'd3);
    run_table("round_robin");

    // Drop of the shown error mid-hold, then all requests cleared.
    do_reset();
    add_v(4'b0110, 2'd0, 4'b1111, 2'd1, 1'b0, 4'b0000);
    add_lit(4'b0110, 0, 2'd1);
    add_lit(4'b0110, 0, 2'd1);
    add_lit(4'b0110, 1, 2'd1);
    add_lit(4'b0110, 1, 2'd1);
    add_lit(4'b0100, 2, 2'd1);
    add_v(4'b0100, 2'd0, 4'b1111, 2'd2, 1'b0, 4'b0000);
    add_lit(4'b0100, 0, 2'd2);
    add_lit(4'b0100, 0, 2'd2);
    add_lit(4'b0100, 1, 2'd2);
    add_lit(4'b0000, 1, 2'd2);
    add_v(4'b0000, 2'd0, 4'b1111, 2'd2, 1'b0, 4'b0000);
    add_v(4'b0000, 2'd0, 4'b1111, 2'd2, 1'b0, 4'b0000);
    add_v(4'b0000, 2'd0, 4'b1111, 2'd2, 1'b0, 4'b0000);
    run_table("drop_clear");

    // Request on the last wrap edge falls: treated as drop, no pulse.
    do_reset();
    add_v(4'b0100, 2'd0, 4'b1111, 2'd2, 1'b0, 4'b0000);
    for (int k = 0; k < HOLD_CYC - 1; k++) add_lit(4'b0100, (k / SCAN_DIV) % 4, 2'd2);
    add_lit(4'b0000, 3, 2'd2);
    add_v(4'b0000, 2'd0, 4'b1111, 2'd2, 1'b0, 4'b0000);
    add_v(4'b0000, 2'd0, 4'b1111, 2'd2, 1'b0, 4'b0000);
    run_table("late_drop");

    // Asynchronous reset in the middle of SHOW.
    do_reset();
    erro_req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
    end
    check("pre_reset_lit", outs(), {2'd1, 4'b1101, 2'd0, 1'b1, 4'b0000});
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("async_reset", outs(), RESET_OUTS);
    @(posedge clock); #1;
    check("held_reset", outs(), RESET_OUTS);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_reset_idle", outs(), {2'd0, 4'b1111, 2'd0, 1'b0, 4'b0000});
    @(posedge clock); #1;
    check("post_reset_show", outs(), {2'd0, 4'b1110, 2'd0, 1'b1, 4'b0000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
